// File: rtl/zap_mode16_decode_buffer_pkg.sv
// Shared types for the compressed-decoder output buffer: the buffered entry and pointer/count width helpers.
// No logic here; latency and backpressure belong to the modules that import it.
package zap_mode16_decode_buffer_pkg;

   localparam int ZAP_INSN_W = 35;
   localparam int ZAP_PRED_W = 33;

   typedef struct packed {
      logic [ZAP_INSN_W-1:0] instruction;
      logic                  und;
      logic                  force32_align;
      logic                  irq;
      logic                  fiq;
      logic                  iabort;
      logic [31:0]           pc_ff;
      logic [31:0]           pc_plus_8_ff;
      logic [ZAP_PRED_W-1:0] pred;
      logic [1:0]            taken;
   } entry_t;

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/zap_decode_fifo_mem.sv
// DEPTH x entry storage, one write port and an asynchronous read port; no reset on storage.
// Write lands on the clock edge, read is combinational; no flow control of its own.
module zap_decode_fifo_mem
   import zap_mode16_decode_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             i_clk,
   input  logic             i_wr_vld,
   input  logic [PTR_W-1:0] i_wr_addr,
   input  entry_t           i_wr_dat,
   input  logic [PTR_W-1:0] i_rd_addr,
   output entry_t           o_rd_dat
);

   entry_t mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_wr_vld) begin
         mem[i_wr_addr] <= i_wr_dat;
      end
   end

   assign o_rd_dat = mem[i_rd_addr];

endmodule

// File: rtl/zap_mode16_decode_buffer.sv
// Decoded-instruction FIFO plus registered output stage between the 16-bit and 32-bit decoders.
// Latency 1 cycle when empty (bypass); o_ready drops when the FIFO holds DEPTH entries.
module zap_mode16_decode_buffer
   import zap_mode16_decode_buffer_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int INSN_W = ZAP_INSN_W,
   parameter int PRED_W = ZAP_PRED_W
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_clear_from_writeback,
   input  logic                       i_clear_from_alu,
   input  logic                       i_clear_from_decode,
   input  logic                       i_data_stall,
   input  logic                       i_stall_from_shifter,
   input  logic                       i_stall_from_issue,
   input  logic                       i_stall_from_decode,
   input  logic                       i_valid,
   output logic                       o_ready,
   input  logic [INSN_W-1:0]          i_instruction,
   input  logic                       i_und,
   input  logic                       i_force32_align,
   input  logic                       i_irq,
   input  logic                       i_fiq,
   input  logic                       i_iabort,
   input  logic [31:0]                i_pc_ff,
   input  logic [31:0]                i_pc_plus_8_ff,
   input  logic [PRED_W-1:0]          i_pred,
   input  logic [1:0]                 i_taken,
   output logic [INSN_W-1:0]          o_instruction,
   output logic                       o_instruction_valid,
   output logic                       o_und,
   output logic                       o_force32_align,
   output logic                       o_irq,
   output logic                       o_fiq,
   output logic                       o_iabort,
   output logic [31:0]                o_pc_ff,
   output logic [31:0]                o_pc_plus_8_ff,
   output logic [PRED_W-1:0]          o_pred,
   output logic [1:0]                 o_taken_ff,
   output logic [10:0]                o_offset,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int PTR_W = ptr_w(DEPTH);
   localparam int CNT_W = cnt_w(DEPTH);

   logic             stall;
   logic             flush;
   logic             accept;
   logic             fifo_nonempty;
   logic             pop;
   logic             push;
   logic             load_out;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   entry_t           in_entry;
   entry_t           head_entry;
   entry_t           next_out;

   assign stall = i_stall_from_shifter | i_stall_from_issue | i_stall_from_decode | i_data_stall;
   assign flush = i_clear_from_writeback | (i_clear_from_alu & ~i_data_stall) |
                  (i_clear_from_decode & ~stall);

   assign o_ready       = (o_count != CNT_W'(DEPTH));
   assign accept        = i_valid & o_ready & ~flush;
   assign fifo_nonempty = (o_count != '0);
   assign pop           = ~stall & ~flush & fifo_nonempty;
   // Only an empty, unstalled buffer bypasses; everything else goes through storage to keep order.
   assign push          = accept & (stall | fifo_nonempty);
   assign load_out      = ~stall & ~flush & (fifo_nonempty | accept);

   always_comb begin
      in_entry               = '0;
      in_entry.instruction   = i_instruction;
      in_entry.und           = i_und;
      in_entry.force32_align = i_force32_align;
      in_entry.irq           = i_irq;
      in_entry.fiq           = i_fiq;
      in_entry.iabort        = i_iabort;
      in_entry.pc_ff         = i_pc_ff;
      in_entry.pc_plus_8_ff  = i_pc_plus_8_ff;
      in_entry.pred          = i_pred;
      in_entry.taken         = i_taken;
      next_out               = fifo_nonempty ? head_entry : in_entry;
   end

   zap_decode_fifo_mem #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_mem (
      .i_clk     (i_clk),
      .i_wr_vld  (push),
      .i_wr_addr (wr_ptr),
      .i_wr_dat  (in_entry),
      .i_rd_addr (rd_ptr),
      .o_rd_dat  (head_entry)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_count <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
      end else if (flush) begin
         o_count <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
      end else begin
         o_count <= o_count + CNT_W'(push) - CNT_W'(pop);
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   // Offset tracks enqueue order so BL prefix/suffix pairing ignores downstream stalls.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)     o_offset <= '0;
      else if (flush)  o_offset <= '0;
      else if (accept) o_offset <= i_instruction[10:0];
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_instruction       <= '0;
         o_instruction_valid <= 1'b0;
         o_und               <= 1'b0;
         o_force32_align     <= 1'b0;
         o_irq               <= 1'b0;
         o_fiq               <= 1'b0;
         o_iabort            <= 1'b0;
         o_pc_ff             <= '0;
         o_pc_plus_8_ff      <= '0;
         o_pred              <= '0;
         o_taken_ff          <= '0;
      end else if (load_out) begin
         o_instruction       <= next_out.instruction;
         o_instruction_valid <= 1'b1;
         o_und               <= next_out.und;
         o_force32_align     <= next_out.force32_align;
         o_irq               <= next_out.irq;
         o_fiq               <= next_out.fiq;
         o_iabort            <= next_out.iabort;
         o_pc_ff             <= next_out.pc_ff;
         o_pc_plus_8_ff      <= next_out.pc_plus_8_ff;
         o_pred              <= next_out.pred;
         o_taken_ff          <= next_out.taken;
      end else if (flush || !stall) begin
         o_instruction_valid <= 1'b0;
         o_und               <= 1'b0;
         o_irq               <= 1'b0;
         o_fiq               <= 1'b0;
         o_iabort            <= 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         assert (o_count <= CNT_W'(DEPTH));
         assert (!(pop && (o_count == '0)));
         assert (!(push && !pop && (o_count == CNT_W'(DEPTH))));
      end
   end

endmodule

// File: tb/tb_zap_mode16_decode_buffer.sv
// Directed self-checking bench for zap_mode16_decode_buffer with DEPTH=4.
module tb_zap_mode16_decode_buffer;

   logic        i_clk;
   logic        i_reset;
   logic        i_clear_from_writeback;
   logic        i_clear_from_alu;
   logic        i_clear_from_decode;
   logic        i_data_stall;
   logic        i_stall_from_shifter;
   logic        i_stall_from_issue;
   logic        i_stall_from_decode;
   logic        i_valid;
   logic        o_ready;
   logic [34:0] i_instruction;
   logic        i_und;
   logic        i_force32_align;
   logic        i_irq;
   logic        i_fiq;
   logic        i_iabort;
   logic [31:0] i_pc_ff;
   logic [31:0] i_pc_plus_8_ff;
   logic [32:0] i_pred;
   logic [1:0]  i_taken;
   logic [34:0] o_instruction;
   logic        o_instruction_valid;
   logic        o_und;
   logic        o_force32_align;
   logic        o_irq;
   logic        o_fiq;
   logic        o_iabort;
   logic [31:0] o_pc_ff;
   logic [31:0] o_pc_plus_8_ff;
   logic [32:0] o_pred;
   logic [1:0]  o_taken_ff;
   logic [10:0] o_offset;
   logic [2:0]  o_count;

   int checks   = 0;
   int failures = 0;

   zap_mode16_decode_buffer #(
      .DEPTH  (4),
      .INSN_W (35),
      .PRED_W (33)
   ) dut (
      .i_clk                  (i_clk),
      .i_reset                (i_reset),
      .i_clear_from_writeback (i_clear_from_writeback),
      .i_clear_from_alu       (i_clear_from_alu),
      .i_clear_from_decode    (i_clear_from_decode),
      .i_data_stall           (i_data_stall),
      .i_stall_from_shifter   (i_stall_from_shifter),
      .i_stall_from_issue     (i_stall_from_issue),
      .i_stall_from_decode    (i_stall_from_decode),
      .i_valid                (i_valid),
      .o_ready                (o_ready),
      .i_instruction          (i_instruction),
      .i_und                  (i_und),
      .i_force32_align        (i_force32_align),
      .i_irq                  (i_irq),
      .i_fiq                  (i_fiq),
      .i_iabort               (i_iabort),
      .i_pc_ff                (i_pc_ff),
      .i_pc_plus_8_ff         (i_pc_plus_8_ff),
      .i_pred                 (i_pred),
      .i_taken                (i_taken),
      .o_instruction          (o_instruction),
      .o_instruction_valid    (o_instruction_valid),
      .o_und                  (o_und),
      .o_force32_align        (o_force32_align),
      .o_irq                  (o_irq),
      .o_fiq                  (o_fiq),
      .o_iabort               (o_iabort),
      .o_pc_ff                (o_pc_ff),
      .o_pc_plus_8_ff         (o_pc_plus_8_ff),
      .o_pred                 (o_pred),
      .o_taken_ff             (o_taken_ff),
      .o_offset               (o_offset),
      .o_count                (o_count)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [34:0] ins, input logic [31:0] pc);
      i_valid        = v;
      i_instruction  = ins;
      i_pc_ff        = pc;
      i_pc_plus_8_ff = pc + 32'd8;
      i_pred         = {1'b0, pc};
      i_taken        = 2'b10;
   endtask

   initial begin
      i_reset = 1'b1;
      i_clear_from_writeback = 0; i_clear_from_alu = 0; i_clear_from_decode = 0;
      i_data_stall = 0; i_stall_from_shifter = 0; i_stall_from_issue = 0; i_stall_from_decode = 0;
      i_und = 0; i_force32_align = 0; i_irq = 0; i_fiq = 0; i_iabort = 0;
      drive(1'b0, 35'h0, 32'h0);

      tick(); tick();
      chk("rst_valid",  64'(o_instruction_valid), 64'd0);
      chk("rst_count",  64'(o_count), 64'd0);
      chk("rst_ready",  64'(o_ready), 64'd1);
      chk("rst_offset", 64'(o_offset), 64'd0);
      chk("rst_insn",   64'(o_instruction), 64'd0);
      chk("rst_pc",     64'(o_pc_ff), 64'd0);
      chk("rst_pred",   64'(o_pred), 64'd0);
      chk("rst_taken",  64'(o_taken_ff), 64'd0);
      i_reset = 1'b0;

      // Bypass from empty
      drive(1'b1, 35'h1A, 32'h100); i_irq = 1'b1;
      tick();
      i_irq = 1'b0; drive(1'b0, 35'h0, 32'h0);
      chk("bp_valid",  64'(o_instruction_valid), 64'd1);
      chk("bp_insn",   64'(o_instruction), 64'h1A);
      chk("bp_pc",     64'(o_pc_ff), 64'h100);
      chk("bp_pc8",    64'(o_pc_plus_8_ff), 64'h108);
      chk("bp_irq",    64'(o_irq), 64'd1);
      chk("bp_taken",  64'(o_taken_ff), 64'd2);
      chk("bp_count",  64'(o_count), 64'd0);
      chk("bp_offset", 64'(o_offset), 64'h1A);
      tick();
      chk("idle_valid", 64'(o_instruction_valid), 64'd0);
      chk("idle_irq",   64'(o_irq), 64'd0);
      chk("idle_insn",  64'(o_instruction), 64'h1A);

      // Fill to DEPTH under stall, fifth entry held off
      i_stall_from_issue = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 35'(32'h200 + i), 32'h1000 + 32'(4 * i));
         tick();
      end
      chk("fill_count", 64'(o_count), 64'd4);
      chk("fill_ready", 64'(o_ready), 64'd0);
      chk("fill_valid", 64'(o_instruction_valid), 64'd0);
      drive(1'b1, 35'h204, 32'h1010);
      tick();
      chk("full_count",  64'(o_count), 64'd4);
      chk("full_offset", 64'(o_offset), 64'h203);
      i_stall_from_issue = 1'b0;
      tick();
      chk("drain0_insn",  64'(o_instruction), 64'h200);
      chk("drain0_valid", 64'(o_instruction_valid), 64'd1);
      chk("drain0_count", 64'(o_count), 64'd3);
      tick();
      chk("drain1_insn",   64'(o_instruction), 64'h201);
      chk("drain1_count",  64'(o_count), 64'd3);
      chk("drain1_offset", 64'(o_offset), 64'h204);
      drive(1'b0, 35'h0, 32'h0);
      for (int k = 2; k <= 4; k++) begin
         tick();
         chk("drain_insn",  64'(o_instruction), 64'(32'h200 + k));
         chk("drain_pc",    64'(o_pc_ff), 64'(32'h1000 + 4 * k));
         chk("drain_count", 64'(o_count), 64'(4 - k));
      end
      tick();
      chk("drain_end_valid", 64'(o_instruction_valid), 64'd0);

      // Sustained push/pop at count 2 across pointer wrap
      i_stall_from_issue = 1'b1;
      for (int j = 0; j < 2; j++) begin
         drive(1'b1, 35'(32'h300 + j), 32'h2000 + 32'(4 * j));
         tick();
      end
      chk("stream_pre_count", 64'(o_count), 64'd2);
      i_stall_from_issue = 1'b0;
      for (int t = 0; t < 10; t++) begin
         drive(1'b1, 35'(32'h300 + t + 2), 32'h2000 + 32'(4 * (t + 2)));
         tick();
         chk("stream_insn",  64'(o_instruction), 64'(32'h300 + t));
         chk("stream_pc",    64'(o_pc_ff), 64'(32'h2000 + 4 * t));
         chk("stream_count", 64'(o_count), 64'd2);
      end
      drive(1'b0, 35'h0, 32'h0);
      tick();
      chk("stream_tail0_insn",  64'(o_instruction), 64'h30A);
      chk("stream_tail0_count", 64'(o_count), 64'd1);
      tick();
      chk("stream_tail1_insn",  64'(o_instruction), 64'h30B);
      chk("stream_tail1_count", 64'(o_count), 64'd0);

      // ALU clear is ignored during a data stall, then flushes once the stall drops
      drive(1'b1, 35'h3FF, 32'h3000);
      tick();
      chk("pre_flush_valid", 64'(o_instruction_valid), 64'd1);
      i_data_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 35'(32'h400 + i), 32'h3100 + 32'(4 * i));
         tick();
      end
      drive(1'b0, 35'h0, 32'h0);
      i_clear_from_alu = 1'b1;
      tick();
      chk("noflush_count",  64'(o_count), 64'd3);
      chk("noflush_valid",  64'(o_instruction_valid), 64'd1);
      chk("noflush_insn",   64'(o_instruction), 64'h3FF);
      chk("noflush_offset", 64'(o_offset), 64'h402);
      i_data_stall = 1'b0;
      drive(1'b1, 35'h4FF, 32'h4000);
      tick();
      chk("flush_count",  64'(o_count), 64'd0);
      chk("flush_valid",  64'(o_instruction_valid), 64'd0);
      chk("flush_offset", 64'(o_offset), 64'd0);
      chk("flush_ready",  64'(o_ready), 64'd1);
      i_clear_from_alu = 1'b0;
      drive(1'b0, 35'h0, 32'h0);
      tick();
      chk("flush_drop_valid", 64'(o_instruction_valid), 64'd0);
      chk("flush_drop_count", 64'(o_count), 64'd0);

      // Decode clear is ignored while stalled, takes effect when unstalled
      i_stall_from_shifter = 1'b1; i_clear_from_decode = 1'b1;
      drive(1'b1, 35'h500, 32'h4100);
      tick();
      chk("dec_noflush_count", 64'(o_count), 64'd1);
      i_stall_from_shifter = 1'b0;
      drive(1'b0, 35'h0, 32'h0);
      tick();
      chk("dec_flush_count", 64'(o_count), 64'd0);
      chk("dec_flush_valid", 64'(o_instruction_valid), 64'd0);
      i_clear_from_decode = 1'b0;

      // BL offset captured at enqueue and held through stalls
      drive(1'b1, 35'hF123, 32'h5000);
      tick();
      chk("bl_offset", 64'(o_offset), 64'h123);
      chk("bl_valid",  64'(o_instruction_valid), 64'd1);
      drive(1'b0, 35'h0, 32'h0);
      i_stall_from_decode = 1'b1;
      for (int s = 0; s < 3; s++) begin
         tick();
         chk("bl_hold_offset", 64'(o_offset), 64'h123);
      end

      // Asynchronous reset between clock edges
      drive(1'b1, 35'h600, 32'h6000);
      tick();
      drive(1'b1, 35'h601, 32'h6004);
      tick();
      drive(1'b0, 35'h0, 32'h0);
      chk("ar_pre_count", 64'(o_count), 64'd2);
      chk("ar_pre_valid", 64'(o_instruction_valid), 64'd1);
      #3;
      i_reset = 1'b1;
      #1;
      chk("ar_count",  64'(o_count), 64'd0);
      chk("ar_valid",  64'(o_instruction_valid), 64'd0);
      chk("ar_offset", 64'(o_offset), 64'd0);
      chk("ar_insn",   64'(o_instruction), 64'd0);
      chk("ar_pc",     64'(o_pc_ff), 64'd0);
      #2;
      i_reset = 1'b0;
      i_stall_from_decode = 1'b0;
      #1;
      chk("ar_ready", 64'(o_ready), 64'd1);
      tick();
      chk("ar_post_valid", 64'(o_instruction_valid), 64'd0);
      chk("ar_post_count", 64'(o_count), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/zap_mode16_decode_buffer.md
Name: zap_mode16_decode_buffer

Overview:
- Parametrised decoded-instruction buffer between the 16-bit (compressed) decoder and the 32-bit decoder.
- Replaces a single stall-held pipeline register with a DEPTH-entry FIFO plus a registered output stage. Upstream keeps decoding while downstream stalls; upstream sees valid/ready backpressure.
- Carries all sideband fields (PC, prediction, interrupts, aborts) and owns the BL-prefix offset register that feeds back to the compressed decoder.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- INSN_W, 35, decoded instruction width.
- PRED_W, 33, branch predictor state width.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous active-high reset
- i_clear_from_writeback  in  1  unconditional flush
- i_clear_from_alu  in  1  flush, qualified by !i_data_stall
- i_clear_from_decode  in  1  flush, qualified by !stall
- i_data_stall  in  1  memory stall
- i_stall_from_shifter / i_stall_from_issue / i_stall_from_decode  in  1 each  downstream stalls
- i_valid  in  1  upstream entry valid
- o_ready  out  1  buffer can accept
- i_instruction  in  INSN_W  decoded instruction
- i_und, i_force32_align, i_irq, i_fiq, i_iabort  in  1 each  sideband flags
- i_pc_ff, i_pc_plus_8_ff  in  32 each  PCs
- i_pred  in  PRED_W  predictor state
- i_taken  in  2  taken status
- o_instruction  out  INSN_W  head instruction
- o_instruction_valid  out  1  head valid
- o_und, o_force32_align, o_irq, o_fiq, o_iabort  out  1 each  head sideband
- o_pc_ff, o_pc_plus_8_ff  out  32 each  head PCs
- o_pred  out  PRED_W  head prediction
- o_taken_ff  out  2  head taken
- o_offset  out  11  BL-prefix offset to the compressed decoder
- o_count  out  $clog2(DEPTH+1)  FIFO occupancy, excluding the output stage

Behaviour:
- Definitions:
  - stall = i_stall_from_shifter | i_stall_from_issue | i_stall_from_decode | i_data_stall.
  - flush = i_clear_from_writeback | (i_clear_from_alu & !i_data_stall) | (i_clear_from_decode & !stall).
- Reset (async):
  - Pointers and count = 0; o_offset = 0.
  - All outputs = 0, including o_instruction, PCs, o_pred and o_taken_ff.
- Ready and accept:
  - o_ready = (o_count != DEPTH); combinational from the count register only.
  - accept = i_valid & o_ready & !flush.
- Output stage, when !stall and !flush, takes the first matching case:
  - (a) count > 0: load all head fields from FIFO[rd_ptr] and pop. An accept in the same cycle pushes to FIFO[wr_ptr]; count unchanged.
  - (b) count == 0 and accept: bypass the input directly into the output stage; nothing is written to the FIFO. Latency is 1 cycle.
  - (c) otherwise: o_instruction_valid = 0, o_irq/o_fiq/o_und/o_iabort = 0, o_instruction holds its previous value.
- When stall and !flush:
  - Output stage holds all fields.
  - Accepts push into the FIFO; count increments.
- Flush (highest priority after reset):
  - count, rd_ptr, wr_ptr = 0.
  - o_instruction_valid, o_irq, o_fiq, o_und, o_iabort = 0.
  - o_offset = 0.
  - Remaining outputs are don't-care.
  - An input presented in the flush cycle is dropped.
- Pointers: log2(DEPTH) bits, natural wrap-around. Count never exceeds DEPTH or underflows; assertions check both.
- o_offset: on every accept, o_offset <= i_instruction[10:0]. Otherwise it holds. This updates at enqueue, not at dequeue, so the compressed decoder pairs BL prefix/suffix in fetch order independent of downstream stalls.
- Full and simultaneous events:
  - When full, o_ready = 0 and upstream holds.
  - A pop in the same cycle does not re-enable acceptance until the next cycle.
- An entry with i_irq/i_fiq set is buffered like any other entry; it is never reordered or dropped except by flush.

Decomposition:
- Package: the entry struct (instruction, flags, PCs, pred, taken) and the PTR_W/CNT_W derivations. Width constants come from the existing shared defines.
- One sub-module: zap_decode_fifo_mem, a DEPTH x entry register array with one write port and one asynchronous read port, no reset on storage.
- Flush, count, output stage and offset logic live in the top module.

Test Plan:
- Bypass: empty, no stall; push I=0x1A, pc=0x100 -> next cycle o_instruction_valid=1, o_instruction=0x1A, o_pc_ff=0x100; o_count=0.
- Fill: stall held, push 5 entries with DEPTH=4 -> the first 4 are accepted, o_count=4, o_ready=0, the 5th is held. Release stall -> entries emerge in order, one per cycle.
- Simultaneous push/pop: count=2, no stall, push -> count stays 2, ordering preserved across pointer wrap (run 3*DEPTH entries).
- Flush priority: count=3, i_clear_from_alu=1 with i_data_stall=1 -> no flush. Drop i_data_stall -> next cycle count=0, o_instruction_valid=0, o_offset=0.
- BL offset: accept 0xF123 then stall 3 cycles -> o_offset=0x123 immediately after the accept, unchanged while stalled.
- Async reset mid-operation: assert i_reset between clock edges with count=2 -> outputs and count go to 0 without a clock edge; o_ready=1 after release.
